// File: rtl/roic_sync_seq_gen.sv
// ROIC frame-sync / test-pulse sequencer: per frame a SYNC pulse, a programmable gap, then a
// TP_SEL window, repeated for a configured frame count or until abort.
module roic_sync_seq_gen #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned FRAME_W = 8
) (
   input  logic               clk_20mhz,
   input  logic               rst_20mhz,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_W-1:0]   cfg_sync_width,
   input  logic [CNT_W-1:0]   cfg_tp_delay,
   input  logic [CNT_W-1:0]   cfg_tp_width,
   input  logic [FRAME_W-1:0] cfg_frames,
   output logic               fsm_wait_roic_sync,
   output logic               fsm_wait_tp_sel,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [FRAME_W-1:0] frame_cnt
);

   typedef enum logic [2:0] {StIdle, StSync, StGap, StTp, StFin} state_e;

   localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
   localparam logic [FRAME_W:0]   FrameOne = (FRAME_W + 1)'(1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [CNT_W-1:0]   sync_w_q, sync_w_d;
   logic [CNT_W-1:0]   delay_q, delay_d;
   logic [CNT_W-1:0]   tp_w_q, tp_w_d;
   logic [FRAME_W-1:0] frames_q, frames_d;
   logic               err_d;
   logic               eof;
   logic [FRAME_W:0]   frame_inc;

   // One bit wider so the frames-remaining compare cannot wrap at all-ones.
   assign frame_inc = {1'b0, frame_q} + FrameOne;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      frame_d  = frame_q;
      sync_w_d = sync_w_q;
      delay_d  = delay_q;
      tp_w_d   = tp_w_q;
      frames_d = frames_q;
      err_d    = 1'b0;
      eof      = 1'b0;

      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (cfg_sync_width == '0) begin
                     err_d = 1'b1;
                  end else begin
                     state_d  = StSync;
                     cnt_d    = cfg_sync_width - CntOne;
                     frame_d  = '0;
                     sync_w_d = cfg_sync_width;
                     delay_d  = cfg_tp_delay;
                     tp_w_d   = cfg_tp_width;
                     frames_d = cfg_frames;
                  end
               end
            end
            StSync: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CntOne;
               end else if (delay_q != '0) begin
                  state_d = StGap;
                  cnt_d   = delay_q - CntOne;
               end else if (tp_w_q != '0) begin
                  state_d = StTp;
                  cnt_d   = tp_w_q - CntOne;
               end else begin
                  eof = 1'b1;
               end
            end
            StGap: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CntOne;
               end else if (tp_w_q != '0) begin
                  state_d = StTp;
                  cnt_d   = tp_w_q - CntOne;
               end else begin
                  eof = 1'b1;
               end
            end
            StTp: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CntOne;
               end else begin
                  eof = 1'b1;
               end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
         endcase

         if (eof) begin
            frame_d = (&frame_q) ? frame_q : frame_inc[FRAME_W-1:0];
            if (frames_q == '0 || frame_inc < {1'b0, frames_q}) begin
               state_d = StSync;
               cnt_d   = sync_w_q - CntOne;
            end else begin
               state_d = StFin;
            end
         end
      end
   end

   always_ff @(posedge clk_20mhz or posedge rst_20mhz) begin
      if (rst_20mhz) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         frame_q  <= '0;
         sync_w_q <= '0;
         delay_q  <= '0;
         tp_w_q   <= '0;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         frame_q  <= frame_d;
         sync_w_q <= sync_w_d;
         delay_q  <= delay_d;
         tp_w_q   <= tp_w_d;
         frames_q <= frames_d;
      end
   end

   // Outputs are flopped from the next state so they line up with the state register.
   always_ff @(posedge clk_20mhz or posedge rst_20mhz) begin
      if (rst_20mhz) begin
         fsm_wait_roic_sync <= 1'b0;
         fsm_wait_tp_sel    <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         cfg_err            <= 1'b0;
      end else begin
         fsm_wait_roic_sync <= (state_d == StSync);
         fsm_wait_tp_sel    <= (state_d == StTp);
         busy               <= (state_d == StSync) || (state_d == StGap) || (state_d == StTp);
         done               <= (state_d == StFin);
         cfg_err            <= err_d;
      end
   end

   assign frame_cnt = frame_q;

endmodule

// File: tb/tb_roic_sync_seq_gen.sv
// Directed self-checking bench for roic_sync_seq_gen; cycle 1 is the first cycle after the
// clock edge that captures start.
module tb_roic_sync_seq_gen;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned FRAME_W = 8;

   logic               clk_20mhz = 1'b0;
   logic               rst_20mhz = 1'b1;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [CNT_W-1:0]   cfg_sync_width = '0;
   logic [CNT_W-1:0]   cfg_tp_delay = '0;
   logic [CNT_W-1:0]   cfg_tp_width = '0;
   logic [FRAME_W-1:0] cfg_frames = '0;
   logic               fsm_wait_roic_sync;
   logic               fsm_wait_tp_sel;
   logic               busy;
   logic               done;
   logic               cfg_err;
   logic [FRAME_W-1:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   roic_sync_seq_gen #(.CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
      .clk_20mhz          (clk_20mhz),
      .rst_20mhz          (rst_20mhz),
      .start              (start),
      .abort              (abort),
      .cfg_sync_width     (cfg_sync_width),
      .cfg_tp_delay       (cfg_tp_delay),
      .cfg_tp_width       (cfg_tp_width),
      .cfg_frames         (cfg_frames),
      .fsm_wait_roic_sync (fsm_wait_roic_sync),
      .fsm_wait_tp_sel    (fsm_wait_tp_sel),
      .busy               (busy),
      .done               (done),
      .cfg_err            (cfg_err),
      .frame_cnt          (frame_cnt)
   );

   always #25 clk_20mhz = ~clk_20mhz;

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_cyc(input string tag, input int cyc, input logic es, input logic et,
                          input logic eb, input logic ed);
      chk({tag, "_sync"}, cyc, 32'(fsm_wait_roic_sync), 32'(es));
      chk({tag, "_tp"}, cyc, 32'(fsm_wait_tp_sel), 32'(et));
      chk({tag, "_busy"}, cyc, 32'(busy), 32'(eb));
      chk({tag, "_done"}, cyc, 32'(done), 32'(ed));
      chk({tag, "_excl"}, cyc, 32'(!(fsm_wait_roic_sync && fsm_wait_tp_sel)), 32'd1);
   endtask

   task automatic set_cfg(input int w, input int d, input int t, input int f);
      cfg_sync_width = CNT_W'(w);
      cfg_tp_delay   = CNT_W'(d);
      cfg_tp_width   = CNT_W'(t);
      cfg_frames     = FRAME_W'(f);
   endtask

   // Returns just after the capturing edge; the next negedge samples cycle 1.
   task automatic pulse_start();
      @(negedge clk_20mhz);
      start = 1'b1;
      @(posedge clk_20mhz);
      #1 start = 1'b0;
   endtask

   initial begin
      // Reset state
      #10;
      chk("rst_sync", 0, 32'(fsm_wait_roic_sync), 32'd0);
      chk("rst_busy", 0, 32'(busy), 32'd0);
      chk("rst_fcnt", 0, 32'(frame_cnt), 32'd0);
      @(negedge clk_20mhz);
      rst_20mhz = 1'b0;
      @(negedge clk_20mhz);

      // T2 single frame
      set_cfg(4, 2, 3, 1);
      pulse_start();
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk_20mhz);
         chk_cyc("t2", c, c <= 4, c >= 7 && c <= 9, c <= 9, c == 10);
         if (c == 5) set_cfg(1, 0, 0, 9);
      end
      chk("t2_fcnt", 11, 32'(frame_cnt), 32'd1);

      // T3 multi-frame
      set_cfg(2, 0, 1, 3);
      pulse_start();
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk_20mhz);
         chk_cyc("t3", c, (c % 3) != 0 && c <= 9, (c % 3) == 0 && c <= 9, c <= 9, c == 10);
      end
      chk("t3_fcnt", 11, 32'(frame_cnt), 32'd3);

      // T4a no TP window
      set_cfg(2, 1, 0, 2);
      pulse_start();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk_20mhz);
         chk_cyc("t4a", c, c == 1 || c == 2 || c == 4 || c == 5, 1'b0, c <= 6, c == 7);
      end
      chk("t4a_fcnt", 8, 32'(frame_cnt), 32'd2);

      // T4b zero sync width rejected
      set_cfg(0, 1, 1, 1);
      pulse_start();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_20mhz);
         chk("t4b_err", c, 32'(cfg_err), 32'(c == 1));
         chk_cyc("t4b", c, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // T5 continuous, abort in fifth GAP (cycles 18..19)
      set_cfg(1, 2, 1, 0);
      pulse_start();
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk_20mhz);
         chk_cyc("t5", c, (c % 4) == 1, (c % 4) == 0, 1'b1, 1'b0);
      end
      abort = 1'b1;
      @(posedge clk_20mhz);
      #1 abort = 1'b0;
      for (int c = 19; c <= 22; c++) begin
         @(negedge clk_20mhz);
         chk_cyc("t5_ab", c, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("t5_fcnt", 22, 32'(frame_cnt), 32'd4);

      // T6a start while busy, with changed config, is ignored
      set_cfg(3, 0, 2, 1);
      pulse_start();
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk_20mhz);
         chk_cyc("t6a", c, c <= 3, c == 4 || c == 5, c <= 5, c == 6);
         chk("t6a_err", c, 32'(cfg_err), 32'd0);
         if (c == 2) begin
            set_cfg(1, 5, 0, 7);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      chk("t6a_fcnt", 7, 32'(frame_cnt), 32'd1);

      // T6b start and abort together in IDLE
      set_cfg(2, 0, 1, 1);
      @(negedge clk_20mhz);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk_20mhz);
      #1;
      start = 1'b0;
      abort = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_20mhz);
         chk_cyc("t6b", c, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("t6b_err", c, 32'(cfg_err), 32'd0);
      end

      // T1 async reset during second frame's TP window (cycles 16..18)
      set_cfg(4, 2, 3, 2);
      pulse_start();
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk_20mhz);
      end
      chk("t1_pre_tp", 17, 32'(fsm_wait_tp_sel), 32'd1);
      chk("t1_pre_fcnt", 17, 32'(frame_cnt), 32'd1);
      #5 rst_20mhz = 1'b1;
      #1;
      chk_cyc("t1_rst", 17, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_fcnt", 17, 32'(frame_cnt), 32'd0);
      @(negedge clk_20mhz);
      rst_20mhz = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk_20mhz);
         chk_cyc("t1_post", c, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
